// File: rtl/expr_sequencer.sv
// Microprogrammed sequencer for the expression solver: steps the operand mux select and ALU opcode through a writable program.
// Optional feature: define EXPR_SEQ_ABORT_EN to add the abort input.
module expr_sequencer #(
   parameter int PROG_DEPTH = 8,
   localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
`ifdef EXPR_SEQ_ABORT_EN
   input  logic          abort,
`endif
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [4:0]    prog_wdata,
   output logic [1:0]    M,
   output logic [1:0]    alu_op,
   output logic          acc_clr,
   output logic          acc_en,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] step,
   output logic          err
);

   // state | meaning
   // IDLE  | waiting for start, program writable
   // FIRST | load first operand into accumulator (prog[0])
   // EXEC  | fold operand prog[pc] into accumulator
   // DONE  | one-cycle completion pulse
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FIRST = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [AW-1:0] PC_LAST = AW'(PROG_DEPTH - 1);

   logic [1:0]    state;
   logic [AW-1:0] pc;
   logic          err_q;
   logic [4:0]    prog [PROG_DEPTH];
   logic [4:0]    cur_word;
   logic [4:0]    first_word;
   logic          abort_i;
   logic          addr_ok;

`ifdef EXPR_SEQ_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign cur_word   = prog[pc];
   assign first_word = prog[0];
   // Guards non-power-of-two depths against writes past the last step.
   assign addr_ok    = (32'(prog_addr) < PROG_DEPTH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         pc    <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < PROG_DEPTH; i++) begin
            prog[i] <= '0;
         end
      end else begin
         if (prog_we && (state == ST_IDLE) && addr_ok) begin
            prog[prog_addr] <= prog_wdata;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FIRST;
                  pc    <= '0;
                  err_q <= 1'b0;
               end
            end
            ST_FIRST: begin
               if (abort_i) begin
                  state <= ST_IDLE;
                  pc    <= '0;
               end else if (first_word[4]) begin
                  state <= ST_DONE;
               end else begin
                  state <= ST_EXEC;
                  pc    <= AW'(1);
               end
            end
            ST_EXEC: begin
               if (abort_i) begin
                  state <= ST_IDLE;
                  pc    <= '0;
               end else if (cur_word[4]) begin
                  state <= ST_DONE;
               end else if (pc == PC_LAST) begin
                  // Ran off the end without a last marker; pc holds, never wraps.
                  state <= ST_DONE;
                  err_q <= 1'b1;
               end else begin
                  pc <= pc + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      M       = 2'b00;
      alu_op  = 2'b00;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         ST_FIRST: begin
            M       = first_word[1:0];
            acc_clr = ~abort_i;
            busy    = 1'b1;
         end
         ST_EXEC: begin
            M      = cur_word[1:0];
            alu_op = cur_word[3:2];
            acc_en = ~abort_i;
            busy   = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            M = 2'b00;
         end
      endcase
   end

   assign step = pc;
   assign err  = err_q;

endmodule
